// File: rtl/alu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Issues one decoded operation at a time to the PE ALU. Operands
//            and select stay registered and stable until the ALU reports
//            completion. The result and Zero flag are then returned to
//            writeback over a valid/ready handshake. Illegal selects and
//            ALU timeouts are reported in place of a result.
// Ports    : clk, rst (async, active-high)
//            req_*   : decode-side request (valid/ready, operands, sel, rd)
//            alu_*   : registered ALU operands/select, start pulse, and
//                      ALU result/zero/complete inputs
//            wb_*    : writeback response (valid/ready, data, zero, rd,
//                      illegal, timeout)
//            issued_cnt : count of ops sent to the ALU, wraps at 16 bits
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [4:0]        req_sel,
  input  logic [4:0]        req_rd,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [4:0]        alu_sel,
  output logic              alu_start,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_complete,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_zero,
  output logic [4:0]        wb_rd,
  output logic              wb_illegal,
  output logic              wb_timeout,
  output logic [15:0]       issued_cnt
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int                CNT_W       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  c_WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]        c_SEL_MAX   = 5'b10011;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  logic [1:0]        state_q,      state_d;
  logic [DATA_W-1:0] alu_a_q,      alu_a_d;
  logic [DATA_W-1:0] alu_b_q,      alu_b_d;
  logic [4:0]        alu_sel_q,    alu_sel_d;
  logic              alu_start_q,  alu_start_d;
  logic [CNT_W-1:0]  wait_cnt_q,   wait_cnt_d;
  logic [DATA_W-1:0] wb_data_q,    wb_data_d;
  logic              wb_zero_q,    wb_zero_d;
  logic [4:0]        wb_rd_q,      wb_rd_d;
  logic              wb_illegal_q, wb_illegal_d;
  logic              wb_timeout_q, wb_timeout_d;
  logic [15:0]       issued_cnt_q, issued_cnt_d;

  logic w_sel_legal;
  assign w_sel_legal = (req_sel <= c_SEL_MAX);

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    alu_start_d  = 1'b0;
    wait_cnt_d   = wait_cnt_q;
    wb_data_d    = wb_data_q;
    wb_zero_d    = wb_zero_q;
    wb_rd_d      = wb_rd_q;
    wb_illegal_d = wb_illegal_q;
    wb_timeout_d = wb_timeout_q;
    issued_cnt_d = issued_cnt_q;

    case (state_q)
      c_ST_IDLE: begin
        if (req_valid) begin
          wb_rd_d = req_rd;
          if (w_sel_legal) begin
            alu_a_d      = req_a;
            alu_b_d      = req_b;
            alu_sel_d    = req_sel;
            alu_start_d  = 1'b1;
            wait_cnt_d   = '0;
            issued_cnt_d = issued_cnt_q + 16'd1;
            state_d      = c_ST_WAIT;
          end else begin
            // Rejected without touching the ALU-side registers.
            wb_data_d    = '0;
            wb_zero_d    = 1'b0;
            wb_illegal_d = 1'b1;
            state_d      = c_ST_RESP;
          end
        end
      end

      c_ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        // A complete seen in the first WAIT cycle may still be the previous
        // op's level, so it is not trusted until wait_cnt has moved on.
        if (alu_complete && (wait_cnt_q != '0)) begin
          wb_data_d = alu_out;
          wb_zero_d = alu_zero;
          state_d   = c_ST_RESP;
        end else if (wait_cnt_q == c_WAIT_LAST) begin
          wb_data_d    = '0;
          wb_zero_d    = 1'b0;
          wb_timeout_d = 1'b1;
          state_d      = c_ST_RESP;
        end
      end

      c_ST_RESP: begin
        if (wb_ready) begin
          wb_illegal_d = 1'b0;
          wb_timeout_d = 1'b0;
          state_d      = c_ST_IDLE;
        end
      end

      default: state_d = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= c_ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      alu_start_q  <= 1'b0;
      wait_cnt_q   <= '0;
      wb_data_q    <= '0;
      wb_zero_q    <= 1'b0;
      wb_rd_q      <= '0;
      wb_illegal_q <= 1'b0;
      wb_timeout_q <= 1'b0;
      issued_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      alu_start_q  <= alu_start_d;
      wait_cnt_q   <= wait_cnt_d;
      wb_data_q    <= wb_data_d;
      wb_zero_q    <= wb_zero_d;
      wb_rd_q      <= wb_rd_d;
      wb_illegal_q <= wb_illegal_d;
      wb_timeout_q <= wb_timeout_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign req_ready  = (state_q == c_ST_IDLE);
  assign wb_valid   = (state_q == c_ST_RESP);
  assign alu_A      = alu_a_q;
  assign alu_B      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign alu_start  = alu_start_q;
  assign wb_data    = wb_data_q;
  assign wb_zero    = wb_zero_q;
  assign wb_rd      = wb_rd_q;
  assign wb_illegal = wb_illegal_q;
  assign wb_timeout = wb_timeout_q;
  assign issued_cnt = issued_cnt_q;

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Initiator-side controller for the PE ALU operand/select/complete interface. It accepts one decoded operation at a time from the PE decode stage and drives the ALU's operand and select inputs, holding them stable until the ALU signals completion. It then captures the result and Zero flag and presents them to writeback through a valid/ready handshake, with illegal-opcode and timeout protection. It sits between decode and the ALU and replaces ad-hoc operand driving.

## Interface
- DATA_W, 32, operand/result width
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  decode presents an operation
- req_ready  out  1  controller can accept (combinational: state==IDLE)
- req_a, req_b  in  DATA_W  operands
- req_sel  in  5  ALU select; legal codes are 5'b00000..5'b10011
- req_rd  in  5  destination register tag
- alu_A, alu_B  out  DATA_W  registered operands to ALU
- alu_sel  out  5  registered select to ALU
- alu_start  out  1  one-cycle pulse in the first WAIT cycle
- alu_out  in  DATA_W  ALU result
- alu_zero  in  1  ALU Zero flag
- alu_complete  in  1  ALU result-valid level
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_data  out  DATA_W  captured result
- wb_zero  out  1  captured Zero
- wb_rd  out  5  tag of completed op
- wb_illegal  out  1  op rejected, sel > 5'b10011
- wb_timeout  out  1  op aborted by timeout
- issued_cnt  out  16  ops issued to the ALU, wraps at 16'hFFFF→0

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid at the edge:
  - legal sel: latch req_a/req_b/req_sel onto alu_A/alu_B/alu_sel; latch req_rd; clear wait_cnt; increment issued_cnt; go WAIT.
  - illegal sel: ALU outputs unchanged; issued_cnt unchanged; wb_data=0, wb_zero=0, wb_illegal=1, wb_rd=req_rd; go RESP.
- WAIT: alu_A/B/sel held constant. wait_cnt increments each cycle.
  - alu_complete is ignored while wait_cnt==0 (guard against a stale complete from the previous op).
  - If alu_complete=1 with wait_cnt≥1: capture alu_out into wb_data and alu_zero into wb_zero; go RESP.
  - Else if wait_cnt==TIMEOUT_CYCLES-1: set wb_data=0, wb_zero=0, wb_timeout=1; go RESP.
  - Complete takes priority over timeout in the same cycle.
- RESP: wb_valid=1 and all wb_* fields held stable until wb_ready=1 at an edge, then go IDLE. wb_illegal and wb_timeout clear on leaving RESP. alu_A/B/sel keep their last values.
- Only one op is in flight. req_ready=0 throughout WAIT and RESP; requests are never dropped, only stalled.

## Timing
- Reset (async, immediate): state=IDLE, req_ready=1. All of the following are 0: alu_A, alu_B, alu_sel, alu_start, wb_valid, wb_data, wb_zero, wb_rd, wb_illegal, wb_timeout, issued_cnt, wait_cnt.
- Accept at edge E0. alu_* is valid after E0, and alu_start is high in cycle E0→E1.
- Earliest capture is at E2 (complete high during E1→E2). wb_valid rises after E2.
- Handshake at edge Ew returns the block to IDLE. The next accept is possible at Ew+1. Peak throughput is one op per 4 cycles.
- Illegal op: accept at E0, wb_valid after E0.
- Timeout: accept at E0, wb_valid with wb_timeout after E(TIMEOUT_CYCLES).
- Reset asserted in WAIT or RESP aborts the op with no wb_valid. The ALU's later alu_complete is ignored, because the block is in IDLE.

## Test plan
- ADD: req a=5, b=3, sel=00000, rd=7; ALU model asserts complete 2 cycles after alu_start → wb_data=8, wb_zero=0, wb_rd=7, issued_cnt=1, alu_A stays 5 until capture.
- SUB zero and stale complete: alu_complete held high from the previous op through the first WAIT cycle, then real result 5−5 → captured value is 0 with wb_zero=1. The stale value must not be captured.
- Illegal: sel=5'b10100, rd=3 → wb_valid at the next cycle, wb_illegal=1, wb_data=0, alu_start never pulses, issued_cnt unchanged.
- Timeout: TIMEOUT_CYCLES=8, alu_complete tied 0 → wb_timeout=1 exactly 8 edges after accept, wb_data=0; the next op proceeds normally.
- Backpressure: AND F0F0F0F0/0F0F0F0F, wb_ready low for 5 cycles → wb_valid=1, wb_data=0 held stable, req_ready=0 throughout; IDLE the edge after wb_ready=1.
- Reset mid-WAIT: assert rst asynchronously between edges → every output listed above reads 0 and req_ready=1 immediately; a later alu_complete produces no wb_valid.
